tmr_count_unit: RTL

- Count/compare stage of the 8-bit timer channel. Sits directly upstream of the control/status register block.
- Holds TCNT, TCORA and TCORB, and generates the count tick from an internal prescaler or an external clock pin.
- Produces one-cycle pulses: o_overflow, o_cma, o_cmb. The status block feeds these into i_overflow, i_CMA and i_CMB.
- All bus registers are byte-wide, with write enables decoded by the bus interface.

---
 rtl/tmr_pkg.sv | 26 ++
 rtl/tmr_prescaler.sv | 43 ++++
 rtl/tmr_count_unit.sv | 71 +++++++
 3 files changed

// File: rtl/tmr_pkg.sv
// tmr_pkg: shared clock-select/clear codes, widths and prescaler tap lookup for the timer count unit.
package tmr_pkg;
   localparam int TMR_DW = 8;
   localparam int TMR_PRESC_W = 13;
   localparam logic [7:0] TMR_TCOR_RST = 8'hFF;
   typedef enum logic [2:0] {
      CKS_STOP    = 3'b000,
      CKS_DIV2    = 3'b001,
      CKS_DIV8    = 3'b010,
      CKS_DIV64   = 3'b011,
      CKS_DIV8192 = 3'b100,
      CKS_EXT_R   = 3'b101,
      CKS_EXT_F   = 3'b110,
      CKS_EXT_B   = 3'b111
   } cks_e;
   typedef enum logic [1:0] {
      CCLR_NONE = 2'b00,
      CCLR_A    = 2'b01,
      CCLR_B    = 2'b10,
      CCLR_OFF  = 2'b11
   } cclr_e;
   // Number of low prescaler bits that must be all ones for an internal tick; 0 = not an internal divide.
   function automatic int unsigned cks_tap(input logic [2:0] cks);
      return cks == CKS_DIV2 ? 1 : cks == CKS_DIV8 ? 3 : cks == CKS_DIV64 ? 6 : cks == CKS_DIV8192 ? 13 : 0;
   endfunction
endpackage

// File: rtl/tmr_prescaler.sv
// tmr_prescaler: free-running divider plus synchronised external-pin edge detector, muxed into one count tick.
module tmr_prescaler
   import tmr_pkg::*;
#(
   parameter int PRESC_WIDTH = TMR_PRESC_W
) (
   input  logic       i_clk_sys,
   input  logic       i_rst_n,
   input  logic [2:0] i_cks,
   input  logic       i_ext_clk,
   output logic       o_tick
);
   logic [PRESC_WIDTH-1:0] presc_q, presc_d, tap_mask;
   logic                   s1_q, s2_q, p_q;
   logic [1:0]             edge_q, edge_d;
   int unsigned            tap;
   always_comb begin
      tap = cks_tap(i_cks);
      tap_mask = PRESC_WIDTH'((64'd1 << tap) - 64'd1);
      presc_d = presc_q + PRESC_WIDTH'(1);
      edge_d = {s2_q & ~p_q, ~s2_q & p_q};
      o_tick = tap != 0 ? (presc_q & tap_mask) == tap_mask :
               i_cks == CKS_EXT_R ? edge_q[1] :
               i_cks == CKS_EXT_F ? edge_q[0] :
               i_cks == CKS_EXT_B ? |edge_q : 1'b0;
   end
   // edge_q is an extra stage so a pin edge sampled at edge k counts at edge k+3.
   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         presc_q <= '0;
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         p_q <= 1'b0;
         edge_q <= '0;
      end else begin
         presc_q <= presc_d;
         s1_q <= i_ext_clk;
         s2_q <= s1_q;
         p_q <= s2_q;
         edge_q <= edge_d;
      end
   end
endmodule

// File: rtl/tmr_count_unit.sv
// tmr_count_unit: 8-bit timer count/compare stage holding TCNT/TCORA/TCORB and emitting match/overflow pulses.
module tmr_count_unit
   import tmr_pkg::*;
#(
   parameter int                    DATA_WIDTH  = TMR_DW,
   parameter int                    PRESC_WIDTH = TMR_PRESC_W,
   parameter logic [DATA_WIDTH-1:0] TCOR_RST    = TMR_TCOR_RST
) (
   input  logic                  i_clk_sys,
   input  logic                  i_rst_n,
   input  logic [2:0]            i_cks,
   input  logic [1:0]            i_cclr,
   input  logic                  i_tcnt_wren,
   input  logic                  i_tcora_wren,
   input  logic                  i_tcorb_wren,
   input  logic [DATA_WIDTH-1:0] i_datain,
   input  logic                  i_ext_clk,
   output logic [DATA_WIDTH-1:0] o_tcnt,
   output logic [DATA_WIDTH-1:0] o_tcora,
   output logic [DATA_WIDTH-1:0] o_tcorb,
   output logic                  o_overflow,
   output logic                  o_cma,
   output logic                  o_cmb
);
   logic [DATA_WIDTH-1:0] tcnt_q, tcnt_d, tcora_q, tcora_d, tcorb_q, tcorb_d;
   logic                  ovf_q, ovf_d, cma_q, cma_d, cmb_q, cmb_d;
   logic                  tick, cnt, match_a, match_b, clr;
   tmr_prescaler #(.PRESC_WIDTH(PRESC_WIDTH)) u_presc (
      .i_clk_sys(i_clk_sys),
      .i_rst_n  (i_rst_n),
      .i_cks    (i_cks),
      .i_ext_clk(i_ext_clk),
      .o_tick   (tick)
   );
   // A TCNT bus write overrides a coincident tick and suppresses its pulses.
   always_comb begin
      match_a = tcnt_q == tcora_q;
      match_b = tcnt_q == tcorb_q;
      clr = (i_cclr == CCLR_A && match_a) || (i_cclr == CCLR_B && match_b);
      cnt = tick & ~i_tcnt_wren;
      tcnt_d = i_tcnt_wren ? i_datain : cnt ? (clr ? '0 : tcnt_q + DATA_WIDTH'(1)) : tcnt_q;
      tcora_d = i_tcora_wren ? i_datain : tcora_q;
      tcorb_d = i_tcorb_wren ? i_datain : tcorb_q;
      ovf_d = cnt & (tcnt_q == '1);
      cma_d = cnt & match_a;
      cmb_d = cnt & match_b;
   end
   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tcnt_q <= '0;
         tcora_q <= TCOR_RST;
         tcorb_q <= TCOR_RST;
         ovf_q <= 1'b0;
         cma_q <= 1'b0;
         cmb_q <= 1'b0;
      end else begin
         tcnt_q <= tcnt_d;
         tcora_q <= tcora_d;
         tcorb_q <= tcorb_d;
         ovf_q <= ovf_d;
         cma_q <= cma_d;
         cmb_q <= cmb_d;
      end
   end
   assign o_tcnt = tcnt_q;
   assign o_tcora = tcora_q;
   assign o_tcorb = tcorb_q;
   assign o_overflow = ovf_q;
   assign o_cma = cma_q;
   assign o_cmb = cmb_q;
endmodule
